rs_age_issue_queue: RTL and testbench

Second-generation reservation station between rename/dispatch and the functional units. Holds up to RS_ENTRIES_NUM instructions with per-operand ready bits and tags, and snoops CDB_PORTS result buses by physical-register tag. Issues up to FU_NUM instructions per cycle, oldest first. Adds allocation backpressure, occupancy reporting and pipeline flush.

---
 rtl/rs_age_issue_queue_pkg.sv | 34 +++
 rtl/rs_age_issue_queue_age_select.sv | 58 +++++
 rtl/rs_age_issue_queue.sv | 176 +++++++++++++++++
 tb/tb_rs_age_issue_queue.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_age_issue_queue_pkg.sv
// rs_gen2_pkg: shared entry type, default widths and occupancy popcount
// for the age-ordered reservation station.
package rs_gen2_pkg;
   localparam int RS_ENTRIES_DEF = 8;
   localparam int FU_NUM_DEF     = 2;
   localparam int CDB_PORTS_DEF  = 2;
   localparam int REG_VAL_W      = 32;
   localparam int PHYS_TAG_W     = 6;
   localparam int CTRL_W         = 16;
   localparam int PC_W           = 32;
   localparam int RS_MAX_ENTRIES = 64;

   // Field widths follow the package defaults; the top's width parameters must match them.
   typedef struct packed {
      logic                  valid;
      logic [CTRL_W-1:0]     ctrl;
      logic [PHYS_TAG_W-1:0] dst_tag;
      logic [PHYS_TAG_W-1:0] src1_tag;
      logic                  src1_rdy;
      logic [REG_VAL_W-1:0]  src1_val;
      logic [PHYS_TAG_W-1:0] src2_tag;
      logic                  src2_rdy;
      logic [REG_VAL_W-1:0]  src2_val;
      logic                  uses_src2;
      logic [REG_VAL_W-1:0]  imm;
      logic [PC_W-1:0]       pc;
   } rs_entry_t;

   function automatic int unsigned count_ones(input logic [RS_MAX_ENTRIES-1:0] v);
      count_ones = 0;
      for (int i = 0; i < RS_MAX_ENTRIES; i++)
         count_ones += 32'(v[i]);
   endfunction
endpackage

// File: rtl/rs_age_issue_queue_age_select.sv
// rs_age_select: age matrix over the entries and per-FU oldest-eligible pick,
// producing a one-hot grant per functional unit.
module rs_age_select
   import rs_gen2_pkg::*;
#(
   parameter int RS_ENTRIES_NUM = RS_ENTRIES_DEF,
   parameter int FU_NUM         = FU_NUM_DEF
)(
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   flush,
   input  logic                                   alloc_en,
   input  logic [RS_ENTRIES_NUM-1:0]              alloc_oh,
   input  logic [RS_ENTRIES_NUM-1:0]              valid,
   input  logic [RS_ENTRIES_NUM-1:0]              eligible,
   input  logic [FU_NUM-1:0]                      fu_ready,
   output logic [FU_NUM-1:0][RS_ENTRIES_NUM-1:0]  grant
);
   // older[i][j] = entry i was allocated before entry j
   logic [RS_ENTRIES_NUM-1:0][RS_ENTRIES_NUM-1:0] older;
   logic [RS_ENTRIES_NUM-1:0] remaining;
   logic [RS_ENTRIES_NUM-1:0] pick;
   logic                      blocked;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         older <= '0;
      else if (flush)
         older <= '0;
      else if (alloc_en)
         for (int i = 0; i < RS_ENTRIES_NUM; i++)
            for (int j = 0; j < RS_ENTRIES_NUM; j++)
               if (alloc_oh[i])
                  older[i][j] <= 1'b0;
               else if (alloc_oh[j])
                  older[i][j] <= valid[i];
   end

   // Stale rows of freed entries are harmless: a reallocation rewrites both row and column.
   always_comb begin
      remaining = eligible;
      grant     = '0;
      pick      = '0;
      blocked   = 1'b0;
      for (int f = 0; f < FU_NUM; f++) begin
         for (int i = 0; i < RS_ENTRIES_NUM; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < RS_ENTRIES_NUM; j++)
               blocked = blocked | (remaining[j] & older[j][i]);
            pick[i] = remaining[i] & ~blocked;
         end
         if (fu_ready[f]) begin
            grant[f]  = pick;
            remaining = remaining & ~pick;
         end
      end
   end
endmodule

// File: rtl/rs_age_issue_queue.sv
// rs_age_issue_queue: age-ordered reservation station with CDB snoop, oldest-first
// multi-FU issue and flush. `RS_WAKEUP_BYPASS_EN lets a same-cycle CDB match count for select.
module rs_age_issue_queue
   import rs_gen2_pkg::*;
#(
   parameter int RS_ENTRIES_NUM = RS_ENTRIES_DEF,
   parameter int FU_NUM         = FU_NUM_DEF,
   parameter int CDB_PORTS      = CDB_PORTS_DEF,
   parameter int REG_VAL_WIDTH  = REG_VAL_W,
   parameter int PHYS_TAG_WIDTH = PHYS_TAG_W,
   parameter int CTRL_WIDTH     = CTRL_W,
   parameter int PC_WIDTH       = PC_W
)(
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 flush,
   input  logic                                 alloc_valid,
   output logic                                 alloc_ready,
   input  logic [CTRL_WIDTH-1:0]                alloc_ctrl,
   input  logic [PHYS_TAG_WIDTH-1:0]            alloc_dst_tag,
   input  logic [PHYS_TAG_WIDTH-1:0]            alloc_src1_tag,
   input  logic [PHYS_TAG_WIDTH-1:0]            alloc_src2_tag,
   input  logic                                 alloc_src1_rdy,
   input  logic                                 alloc_src2_rdy,
   input  logic [REG_VAL_WIDTH-1:0]             alloc_src1_val,
   input  logic [REG_VAL_WIDTH-1:0]             alloc_src2_val,
   input  logic                                 alloc_uses_src2,
   input  logic [REG_VAL_WIDTH-1:0]             alloc_imm,
   input  logic [PC_WIDTH-1:0]                  alloc_pc,
   input  logic [CDB_PORTS-1:0]                 cdb_valid,
   input  logic [CDB_PORTS*PHYS_TAG_WIDTH-1:0]  cdb_tag,
   input  logic [CDB_PORTS*REG_VAL_WIDTH-1:0]   cdb_val,
   input  logic [FU_NUM-1:0]                    fu_ready,
   output logic [FU_NUM-1:0]                    fu_valid,
   output logic [FU_NUM*CTRL_WIDTH-1:0]         fu_ctrl,
   output logic [FU_NUM*PHYS_TAG_WIDTH-1:0]     fu_dst_tag,
   output logic [FU_NUM*REG_VAL_WIDTH-1:0]      fu_src1_val,
   output logic [FU_NUM*REG_VAL_WIDTH-1:0]      fu_src2_val,
   output logic [FU_NUM*REG_VAL_WIDTH-1:0]      fu_imm,
   output logic [FU_NUM*PC_WIDTH-1:0]           fu_pc,
   output logic [$clog2(RS_ENTRIES_NUM+1)-1:0]  occupancy
);
   localparam int N     = RS_ENTRIES_NUM;
   localparam int OCC_W = $clog2(RS_ENTRIES_NUM+1);

   rs_entry_t ent  [N];
   rs_entry_t view [N];
   rs_entry_t sel  [FU_NUM];
   rs_entry_t new_ent;
   logic [N-1:0] valid_vec, eligible, alloc_oh, issued, hit1, hit2;
   logic [N-1:0][REG_VAL_WIDTH-1:0] cv1, cv2;
   logic [FU_NUM-1:0][N-1:0] grant;
   logic [REG_VAL_WIDTH:0] a1, a2;
   logic do_alloc;

   // {hit, value}; scanning downward makes the lowest matching bus win
   function automatic logic [REG_VAL_WIDTH:0] cdb_lookup(input logic [PHYS_TAG_WIDTH-1:0] tag);
      cdb_lookup = '0;
      for (int b = CDB_PORTS-1; b >= 0; b--)
         if (cdb_valid[b] && cdb_tag[b*PHYS_TAG_WIDTH +: PHYS_TAG_WIDTH] == tag)
            cdb_lookup = {1'b1, cdb_val[b*REG_VAL_WIDTH +: REG_VAL_WIDTH]};
   endfunction

   always_comb begin
      for (int i = 0; i < N; i++) begin
         valid_vec[i]       = ent[i].valid;
         {hit1[i], cv1[i]}  = cdb_lookup(ent[i].src1_tag);
         {hit2[i], cv2[i]}  = cdb_lookup(ent[i].src2_tag);
         view[i]            = ent[i];
`ifdef RS_WAKEUP_BYPASS_EN
         if (!ent[i].src1_rdy && hit1[i]) begin
            view[i].src1_rdy = 1'b1;
            view[i].src1_val = cv1[i];
         end
         if (!ent[i].src2_rdy && hit2[i]) begin
            view[i].src2_rdy = 1'b1;
            view[i].src2_val = cv2[i];
         end
`endif
         eligible[i] = view[i].valid && view[i].src1_rdy &&
                       (view[i].src2_rdy || !view[i].uses_src2) && !flush;
      end
   end

   assign alloc_ready = ~&valid_vec;
   assign do_alloc    = alloc_valid && alloc_ready && !flush;
   assign alloc_oh    = ~valid_vec & (valid_vec + N'(1));
   assign occupancy   = OCC_W'(count_ones(RS_MAX_ENTRIES'(valid_vec)));

   // A source not ready at allocation can still be captured from a same-cycle CDB hit.
   always_comb begin
      a1                = cdb_lookup(alloc_src1_tag);
      a2                = cdb_lookup(alloc_src2_tag);
      new_ent.valid     = 1'b1;
      new_ent.ctrl      = alloc_ctrl;
      new_ent.dst_tag   = alloc_dst_tag;
      new_ent.src1_tag  = alloc_src1_tag;
      new_ent.src1_rdy  = alloc_src1_rdy || a1[REG_VAL_WIDTH];
      new_ent.src1_val  = (!alloc_src1_rdy && a1[REG_VAL_WIDTH]) ? a1[REG_VAL_WIDTH-1:0] : alloc_src1_val;
      new_ent.src2_tag  = alloc_src2_tag;
      new_ent.src2_rdy  = alloc_src2_rdy || a2[REG_VAL_WIDTH];
      new_ent.src2_val  = (!alloc_src2_rdy && a2[REG_VAL_WIDTH]) ? a2[REG_VAL_WIDTH-1:0] : alloc_src2_val;
      new_ent.uses_src2 = alloc_uses_src2;
      new_ent.imm       = alloc_imm;
      new_ent.pc        = alloc_pc;
   end

   rs_age_select #(.RS_ENTRIES_NUM(N), .FU_NUM(FU_NUM)) u_age_select (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .alloc_en (do_alloc),
      .alloc_oh (alloc_oh),
      .valid    (valid_vec),
      .eligible (eligible),
      .fu_ready (fu_ready),
      .grant    (grant)
   );

   always_comb begin
      issued = '0;
      for (int f = 0; f < FU_NUM; f++) begin
         issued = issued | grant[f];
         sel[f] = '0;
         for (int i = 0; i < N; i++)
            if (grant[f][i])
               sel[f] = view[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N; i++)
            ent[i] <= '0;
         fu_valid    <= '0;
         fu_ctrl     <= '0;
         fu_dst_tag  <= '0;
         fu_src1_val <= '0;
         fu_src2_val <= '0;
         fu_imm      <= '0;
         fu_pc       <= '0;
      end else if (flush) begin
         for (int i = 0; i < N; i++)
            ent[i].valid <= 1'b0;
         fu_valid <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (do_alloc && alloc_oh[i])
               ent[i] <= new_ent;
            else begin
               if (issued[i])
                  ent[i].valid <= 1'b0;
               if (!ent[i].src1_rdy && hit1[i]) begin
                  ent[i].src1_rdy <= 1'b1;
                  ent[i].src1_val <= cv1[i];
               end
               if (!ent[i].src2_rdy && hit2[i]) begin
                  ent[i].src2_rdy <= 1'b1;
                  ent[i].src2_val <= cv2[i];
               end
            end
         end
         for (int f = 0; f < FU_NUM; f++) begin
            fu_valid[f] <= |grant[f];
            if (|grant[f]) begin
               fu_ctrl[f*CTRL_WIDTH +: CTRL_WIDTH]             <= sel[f].ctrl;
               fu_dst_tag[f*PHYS_TAG_WIDTH +: PHYS_TAG_WIDTH]  <= sel[f].dst_tag;
               fu_src1_val[f*REG_VAL_WIDTH +: REG_VAL_WIDTH]   <= sel[f].src1_val;
               fu_src2_val[f*REG_VAL_WIDTH +: REG_VAL_WIDTH]   <= sel[f].src2_val;
               fu_imm[f*REG_VAL_WIDTH +: REG_VAL_WIDTH]        <= sel[f].imm;
               fu_pc[f*PC_WIDTH +: PC_WIDTH]                   <= sel[f].pc;
            end
         end
      end
   end
endmodule

// File: tb/tb_rs_age_issue_queue.sv
// tb_rs_age_issue_queue: directed checks of fill, wakeup, capture, age order,
// flush and async reset; expectations follow RS_WAKEUP_BYPASS_EN when defined.
module tb_rs_age_issue_queue;
   localparam int N = 8, F = 2, C = 2, V = 32, T = 6, CW = 16, PW = 32;

   logic clk = 0, reset = 1, flush = 0;
   logic alloc_valid = 0, alloc_ready;
   logic [CW-1:0] alloc_ctrl = '0;
   logic [T-1:0] alloc_dst_tag = '0, alloc_src1_tag = '0, alloc_src2_tag = '0;
   logic alloc_src1_rdy = 0, alloc_src2_rdy = 0, alloc_uses_src2 = 0;
   logic [V-1:0] alloc_src1_val = '0, alloc_src2_val = '0, alloc_imm = '0;
   logic [PW-1:0] alloc_pc = '0;
   logic [C-1:0] cdb_valid = '0;
   logic [C*T-1:0] cdb_tag = '0;
   logic [C*V-1:0] cdb_val = '0;
   logic [F-1:0] fu_ready = '0, fu_valid;
   logic [F*CW-1:0] fu_ctrl;
   logic [F*T-1:0] fu_dst_tag;
   logic [F*V-1:0] fu_src1_val, fu_src2_val, fu_imm;
   logic [F*PW-1:0] fu_pc;
   logic [3:0] occupancy;
   int tests = 0, fails = 0;

   always #5 clk = ~clk;

   rs_age_issue_queue dut (
      .clk(clk), .reset(reset), .flush(flush),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_ctrl(alloc_ctrl),
      .alloc_dst_tag(alloc_dst_tag), .alloc_src1_tag(alloc_src1_tag), .alloc_src2_tag(alloc_src2_tag),
      .alloc_src1_rdy(alloc_src1_rdy), .alloc_src2_rdy(alloc_src2_rdy),
      .alloc_src1_val(alloc_src1_val), .alloc_src2_val(alloc_src2_val),
      .alloc_uses_src2(alloc_uses_src2), .alloc_imm(alloc_imm), .alloc_pc(alloc_pc),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
      .fu_ready(fu_ready), .fu_valid(fu_valid), .fu_ctrl(fu_ctrl), .fu_dst_tag(fu_dst_tag),
      .fu_src1_val(fu_src1_val), .fu_src2_val(fu_src2_val), .fu_imm(fu_imm), .fu_pc(fu_pc),
      .occupancy(occupancy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alloc_valid = 0; cdb_valid = '0; fu_ready = '0; flush = 0;
   endtask

   task automatic put(input logic [CW-1:0] ctrl, input logic [T-1:0] t1, input logic r1, input logic [V-1:0] v1,
                      input logic [T-1:0] t2, input logic r2, input logic [V-1:0] v2, input logic u2);
      alloc_valid = 1; alloc_ctrl = ctrl; alloc_dst_tag = ctrl[T-1:0];
      alloc_src1_tag = t1; alloc_src1_rdy = r1; alloc_src1_val = v1;
      alloc_src2_tag = t2; alloc_src2_rdy = r2; alloc_src2_val = v2; alloc_uses_src2 = u2;
      alloc_imm = {16'h1000, ctrl}; alloc_pc = {16'h8000, ctrl};
   endtask

   task automatic bus(input int b, input logic [T-1:0] tag, input logic [V-1:0] val);
      cdb_valid[b] = 1'b1; cdb_tag[b*T +: T] = tag; cdb_val[b*V +: V] = val;
   endtask

   task automatic test_reset();
      #2;
      tests++; if (fu_valid !== 2'b00) begin fails++; $display("FAIL reset_fu_valid got %b exp 00", fu_valid); end
      tests++; if (occupancy !== 4'd0) begin fails++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
      tests++; if (alloc_ready !== 1'b1) begin fails++; $display("FAIL reset_alloc_ready got %b exp 1", alloc_ready); end
      tests++; if (fu_src1_val !== 64'd0) begin fails++; $display("FAIL reset_payload got %h exp 0", fu_src1_val); end
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 0;
   endtask

   task automatic test_fill();
      idle();
      for (int i = 0; i < 8; i++) begin
         put(CW'(i), 1, 1, 32'(100 + i), 2, 1, 32'(200 + i), 1);
         step();
      end
      tests++; if (occupancy !== 4'd8) begin fails++; $display("FAIL fill_occ got %0d exp 8", occupancy); end
      tests++; if (alloc_ready !== 1'b0) begin fails++; $display("FAIL fill_alloc_ready got %b exp 0", alloc_ready); end
      put(16'h0099, 1, 1, 32'h999, 2, 1, 32'h999, 1);
      step();
      tests++; if (occupancy !== 4'd8) begin fails++; $display("FAIL fill_ninth_occ got %0d exp 8", occupancy); end
      tests++; if (fu_valid !== 2'b00) begin fails++; $display("FAIL fill_no_issue got %b exp 00", fu_valid); end
      alloc_valid = 0; fu_ready = 2'b11;
      for (int k = 0; k < 4; k++) begin
         step();
         tests++; if (fu_valid !== 2'b11) begin fails++; $display("FAIL fill_issue%0d_valid got %b exp 11", k, fu_valid); end
         tests++; if (fu_ctrl !== {CW'(2*k+1), CW'(2*k)}) begin fails++; $display("FAIL fill_issue%0d_ctrl got %h exp %h", k, fu_ctrl, {CW'(2*k+1), CW'(2*k)}); end
         tests++; if (occupancy !== 4'(6 - 2*k)) begin fails++; $display("FAIL fill_issue%0d_occ got %0d exp %0d", k, occupancy, 6 - 2*k); end
      end
      tests++; if (fu_src1_val !== {32'd107, 32'd106}) begin fails++; $display("FAIL fill_src1 got %h exp %h", fu_src1_val, {32'd107, 32'd106}); end
      step();
      tests++; if (fu_valid !== 2'b00) begin fails++; $display("FAIL fill_drained got %b exp 00", fu_valid); end
      idle();
   endtask

   task automatic test_wakeup();
      idle();
      put(16'h0011, 5, 0, 32'h0, 0, 1, 32'h0, 0);
      fu_ready = 2'b11;
      step();
      alloc_valid = 0;
      step();
      tests++; if (fu_valid !== 2'b00) begin fails++; $display("FAIL wake_blocked got %b exp 00", fu_valid); end
      bus(0, 7, 32'h1111); bus(1, 5, 32'hDEAD);
      step();
      cdb_valid = '0;
`ifdef RS_WAKEUP_BYPASS_EN
      tests++; if (fu_valid !== 2'b01) begin fails++; $display("FAIL wake_issue got %b exp 01", fu_valid); end
      tests++; if (fu_src1_val[31:0] !== 32'hDEAD) begin fails++; $display("FAIL wake_val got %h exp dead", fu_src1_val[31:0]); end
      step();
      tests++; if (fu_valid !== 2'b00) begin fails++; $display("FAIL wake_after got %b exp 00", fu_valid); end
`else
      tests++; if (fu_valid !== 2'b00) begin fails++; $display("FAIL wake_early got %b exp 00", fu_valid); end
      step();
      tests++; if (fu_valid !== 2'b01) begin fails++; $display("FAIL wake_issue got %b exp 01", fu_valid); end
      tests++; if (fu_src1_val[31:0] !== 32'hDEAD) begin fails++; $display("FAIL wake_val got %h exp dead", fu_src1_val[31:0]); end
`endif
      tests++; if (fu_ctrl[15:0] !== 16'h0011) begin fails++; $display("FAIL wake_ctrl got %h exp 0011", fu_ctrl[15:0]); end
      idle();
   endtask

   task automatic test_capture();
      idle();
      put(16'h0022, 3, 1, 32'h10, 9, 0, 32'hBAD, 1);
      bus(0, 9, 32'h55); bus(1, 9, 32'h66);
      fu_ready = 2'b01;
      step();
      alloc_valid = 0; cdb_valid = '0;
      tests++; if (fu_valid !== 2'b00) begin fails++; $display("FAIL cap_same_cycle got %b exp 00", fu_valid); end
      step();
      tests++; if (fu_valid !== 2'b01) begin fails++; $display("FAIL cap_issue got %b exp 01", fu_valid); end
      tests++; if (fu_src2_val[31:0] !== 32'h55) begin fails++; $display("FAIL cap_src2 got %h exp 55", fu_src2_val[31:0]); end
      tests++; if (fu_src1_val[31:0] !== 32'h10) begin fails++; $display("FAIL cap_src1 got %h exp 10", fu_src1_val[31:0]); end
      tests++; if (fu_imm[31:0] !== 32'h10000022) begin fails++; $display("FAIL cap_imm got %h exp 10000022", fu_imm[31:0]); end
      tests++; if (fu_pc[31:0] !== 32'h80000022) begin fails++; $display("FAIL cap_pc got %h exp 80000022", fu_pc[31:0]); end
      tests++; if (fu_dst_tag[5:0] !== 6'h22) begin fails++; $display("FAIL cap_dst got %h exp 22", fu_dst_tag[5:0]); end
      idle();
   endtask

   task automatic test_age_order();
      idle();
      put(16'h000A, 20, 0, 0, 0, 1, 0, 0); step();
      put(16'h000B, 1, 1, 0, 0, 1, 0, 0); step();
      put(16'h000C, 1, 1, 0, 2, 1, 0, 1); step();
      alloc_valid = 0; fu_ready = 2'b01;
      step();
      tests++; if (fu_valid !== 2'b01 || fu_ctrl[15:0] !== 16'h000B) begin fails++; $display("FAIL age1_first got %b/%h exp 01/000b", fu_valid, fu_ctrl[15:0]); end
      step();
      tests++; if (fu_valid !== 2'b01 || fu_ctrl[15:0] !== 16'h000C) begin fails++; $display("FAIL age1_second got %b/%h exp 01/000c", fu_valid, fu_ctrl[15:0]); end
      bus(0, 20, 32'h77);
      step();
      cdb_valid = '0;
`ifndef RS_WAKEUP_BYPASS_EN
      tests++; if (fu_valid !== 2'b00) begin fails++; $display("FAIL age1_gap got %b exp 00", fu_valid); end
      step();
`endif
      tests++; if (fu_valid !== 2'b01 || fu_ctrl[15:0] !== 16'h000A) begin fails++; $display("FAIL age1_third got %b/%h exp 01/000a", fu_valid, fu_ctrl[15:0]); end
      tests++; if (fu_src1_val[31:0] !== 32'h77) begin fails++; $display("FAIL age1_val got %h exp 77", fu_src1_val[31:0]); end
      idle();
      put(16'h001A, 21, 0, 0, 0, 1, 0, 0); step();
      put(16'h001B, 1, 1, 0, 0, 1, 0, 0); step();
      put(16'h001C, 1, 1, 0, 0, 1, 0, 0); step();
      alloc_valid = 0; fu_ready = 2'b01;
      bus(1, 21, 32'h99);
      step();
      cdb_valid = '0;
`ifdef RS_WAKEUP_BYPASS_EN
      tests++; if (fu_ctrl[15:0] !== 16'h001A) begin fails++; $display("FAIL age2_first got %h exp 001a", fu_ctrl[15:0]); end
      step();
      tests++; if (fu_ctrl[15:0] !== 16'h001B) begin fails++; $display("FAIL age2_second got %h exp 001b", fu_ctrl[15:0]); end
`else
      tests++; if (fu_ctrl[15:0] !== 16'h001B) begin fails++; $display("FAIL age2_first got %h exp 001b", fu_ctrl[15:0]); end
      step();
      tests++; if (fu_ctrl[15:0] !== 16'h001A) begin fails++; $display("FAIL age2_second got %h exp 001a", fu_ctrl[15:0]); end
`endif
      step();
      tests++; if (fu_valid !== 2'b01 || fu_ctrl[15:0] !== 16'h001C) begin fails++; $display("FAIL age2_third got %b/%h exp 01/001c", fu_valid, fu_ctrl[15:0]); end
      tests++; if (occupancy !== 4'd0) begin fails++; $display("FAIL age2_occ got %0d exp 0", occupancy); end
      idle();
   endtask

   task automatic test_back_to_back();
      idle();
      put(16'h0031, 1, 1, 0, 0, 1, 0, 0);
      step();
      put(16'h0032, 1, 1, 0, 0, 1, 0, 0);
      fu_ready = 2'b01;
      step();
      tests++; if (fu_valid !== 2'b01 || fu_ctrl[15:0] !== 16'h0031) begin fails++; $display("FAIL b2b_first got %b/%h exp 01/0031", fu_valid, fu_ctrl[15:0]); end
      tests++; if (occupancy !== 4'd1) begin fails++; $display("FAIL b2b_occ got %0d exp 1", occupancy); end
      alloc_valid = 0;
      step();
      tests++; if (fu_valid !== 2'b01 || fu_ctrl[15:0] !== 16'h0032) begin fails++; $display("FAIL b2b_second got %b/%h exp 01/0032", fu_valid, fu_ctrl[15:0]); end
      tests++; if (occupancy !== 4'd0) begin fails++; $display("FAIL b2b_empty got %0d exp 0", occupancy); end
      idle();
   endtask

   task automatic test_flush();
      idle();
      for (int i = 0; i < 5; i++) begin
         put(CW'(16'h50 + i), 1, 1, 0, 0, 1, 0, 0);
         step();
      end
      tests++; if (occupancy !== 4'd5) begin fails++; $display("FAIL flush_pre_occ got %0d exp 5", occupancy); end
      put(16'h005F, 1, 1, 0, 0, 1, 0, 0);
      flush = 1; fu_ready = 2'b11;
      step();
      tests++; if (occupancy !== 4'd0) begin fails++; $display("FAIL flush_occ got %0d exp 0", occupancy); end
      tests++; if (fu_valid !== 2'b00) begin fails++; $display("FAIL flush_fu_valid got %b exp 00", fu_valid); end
      tests++; if (alloc_ready !== 1'b1) begin fails++; $display("FAIL flush_alloc_ready got %b exp 1", alloc_ready); end
      flush = 0; alloc_valid = 0;
      step();
      tests++; if (occupancy !== 4'd0 || fu_valid !== 2'b00) begin fails++; $display("FAIL flush_after got %0d/%b exp 0/00", occupancy, fu_valid); end
      idle();
   endtask

   task automatic test_async_reset();
      idle();
      for (int i = 0; i < 3; i++) begin
         put(CW'(16'h70 + i), 1, 1, 0, 0, 1, 0, 0);
         step();
      end
      alloc_valid = 0; fu_ready = 2'b01;
      step();
      tests++; if (fu_valid !== 2'b01 || occupancy !== 4'd2) begin fails++; $display("FAIL areset_pre got %b/%0d exp 01/2", fu_valid, occupancy); end
      #2 reset = 1;
      #1;
      tests++; if (fu_valid !== 2'b00) begin fails++; $display("FAIL areset_fu_valid got %b exp 00", fu_valid); end
      tests++; if (occupancy !== 4'd0) begin fails++; $display("FAIL areset_occ got %0d exp 0", occupancy); end
      tests++; if (fu_ctrl !== 32'd0) begin fails++; $display("FAIL areset_payload got %h exp 0", fu_ctrl); end
      tests++; if (alloc_ready !== 1'b1) begin fails++; $display("FAIL areset_alloc_ready got %b exp 1", alloc_ready); end
      @(negedge clk) reset = 0;
      idle();
   endtask

   initial begin
      test_reset();
      test_fill();
      test_wakeup();
      test_capture();
      test_age_order();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
